// File: rtl/alu_operand_stage_if.sv
// Fetch-to-operand-stage handshake bundle.
// Ports: if_valid/if_inst/if_pc from fetch, if_ready back from the stage.
interface alu_operand_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;

  modport master (
    output if_valid,
    output if_inst,
    output if_pc,
    input  if_ready
  );

  modport slave (
    input  if_valid,
    input  if_inst,
    input  if_pc,
    output if_ready
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Decode/issue register: immediate generation, operand select with
// writeback forwarding, stall hold with operand refresh, and flush kill.
// Ports: clk, rst_n (sync, active low); fe (fetch handshake, slave);
//   rs1_addr/rs2_addr, rf_rdata1/2 (regfile read); wb_* (writeback);
//   stall_in, flush; ex_* and alu_* registered ALU-facing outputs.
module alu_operand_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_operand_stage_if.slave fe,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rf_rdata1,
  input  logic [XLEN-1:0]  rf_rdata2,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             stall_in,
  input  logic             flush,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  alu_data_a,
  output logic [XLEN-1:0]  alu_data_b,
  output logic [3:0]       alu_sel,
  output logic [31:0]      alu_inst,
  output logic [XLEN-1:0]  ex_rs2_data
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] data_a_q, data_a_d;
  logic [XLEN-1:0] data_b_q, data_b_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic            a_reg_q, a_reg_d;
  logic            b_reg_q, b_reg_d;
  logic            s2_reg_q, s2_reg_d;

  logic [31:0]     inst;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] cap_a, cap_b;
  logic [3:0]      cap_sel;
  logic            cap_a_reg, cap_b_reg;
  logic            wb_hit;

  assign inst        = fe.if_inst;
  assign opc         = inst[6:0];
  assign f3          = inst[14:12];
  assign rs1_addr    = inst[19:15];
  assign rs2_addr    = inst[24:20];
  assign fe.if_ready = !stall_in;
  assign wb_hit      = wb_valid && (wb_rd != 5'd0);

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  // x0 wins over forwarding; wb_hit already excludes rd=0
  always_comb begin
    rs1_val = rf_rdata1;
    rs2_val = rf_rdata2;
    if (wb_hit && wb_rd == rs1_addr) rs1_val = wb_data;
    if (wb_hit && wb_rd == rs2_addr) rs2_val = wb_data;
    if (rs1_addr == 5'd0) rs1_val = '0;
    if (rs2_addr == 5'd0) rs2_val = '0;
  end

  always_comb begin
    cap_a     = '0;
    cap_b     = '0;
    cap_sel   = 4'b0000;
    cap_a_reg = 1'b0;
    cap_b_reg = 1'b0;
    unique case (1'b1)
      opc == OPC_OP: begin
        cap_a     = rs1_val;
        cap_b     = rs2_val;
        cap_sel   = {inst[30], f3};
        cap_a_reg = 1'b1;
        cap_b_reg = 1'b1;
      end
      opc == OPC_OP_IMM: begin
        cap_a     = rs1_val;
        cap_b     = imm_i;
        // bit30 only qualifies shifts-right; elsewhere it is immediate
        cap_sel   = {(f3 == 3'b101) & inst[30], f3};
        cap_a_reg = 1'b1;
      end
      opc == OPC_LOAD, opc == OPC_JALR: begin
        cap_a     = rs1_val;
        cap_b     = imm_i;
        cap_a_reg = 1'b1;
      end
      opc == OPC_STORE: begin
        cap_a     = rs1_val;
        cap_b     = imm_s;
        cap_a_reg = 1'b1;
      end
      opc == OPC_BRANCH: begin
        cap_a = fe.if_pc;
        cap_b = imm_b;
      end
      opc == OPC_JAL: begin
        cap_a = fe.if_pc;
        cap_b = imm_j;
      end
      opc == OPC_AUIPC: begin
        cap_a = fe.if_pc;
        cap_b = imm_u;
      end
      opc == OPC_LUI: begin
        cap_b = imm_u;
      end
      default: begin
        cap_a = '0;
      end
    endcase
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    sel_d      = sel_q;
    inst_d     = inst_q;
    rs2_data_d = rs2_data_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    a_reg_d    = a_reg_q;
    b_reg_d    = b_reg_q;
    s2_reg_d   = s2_reg_q;
    if (flush || (!stall_in && !fe.if_valid)) begin
      ex_valid_d = 1'b0;
      ex_pc_d    = '0;
      data_a_d   = '0;
      data_b_d   = '0;
      sel_d      = 4'b0000;
      inst_d     = NOP_INST;
      rs2_data_d = '0;
      rs1_d      = 5'd0;
      rs2_d      = 5'd0;
      a_reg_d    = 1'b0;
      b_reg_d    = 1'b0;
      s2_reg_d   = 1'b0;
    end else if (stall_in) begin
      // keep held register operands coherent with retiring writes
      if (wb_hit && a_reg_q && wb_rd == rs1_q) data_a_d = wb_data;
      if (wb_hit && b_reg_q && wb_rd == rs2_q) data_b_d = wb_data;
      if (wb_hit && s2_reg_q && wb_rd == rs2_q) rs2_data_d = wb_data;
    end else begin
      ex_valid_d = 1'b1;
      ex_pc_d    = fe.if_pc;
      data_a_d   = cap_a;
      data_b_d   = cap_b;
      sel_d      = cap_sel;
      inst_d     = inst;
      rs2_data_d = rs2_val;
      rs1_d      = rs1_addr;
      rs2_d      = rs2_addr;
      a_reg_d    = cap_a_reg;
      b_reg_d    = cap_b_reg;
      s2_reg_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      sel_q      <= 4'b0000;
      inst_q     <= NOP_INST;
      rs2_data_q <= '0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      a_reg_q    <= 1'b0;
      b_reg_q    <= 1'b0;
      s2_reg_q   <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      sel_q      <= sel_d;
      inst_q     <= inst_d;
      rs2_data_q <= rs2_data_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      a_reg_q    <= a_reg_d;
      b_reg_q    <= b_reg_d;
      s2_reg_q   <= s2_reg_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign alu_data_a  = data_a_q;
  assign alu_data_b  = data_b_q;
  assign alu_sel     = sel_q;
  assign alu_inst    = inst_q;
  assign ex_rs2_data = rs2_data_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage.
// Hand-encoded instructions with hand-computed operand/select values.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall_in, flush;
  logic        ex_valid;
  logic [31:0] ex_pc, alu_data_a, alu_data_b, alu_inst, ex_rs2_data;
  logic [3:0]  alu_sel;

  int n_cmp = 0;
  int n_err = 0;

  alu_operand_stage_if fe ();

  alu_operand_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fe          (fe.slave),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .stall_in    (stall_in),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .alu_data_a  (alu_data_a),
    .alu_data_b  (alu_data_b),
    .alu_sel     (alu_sel),
    .alu_inst    (alu_inst),
    .ex_rs2_data (ex_rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    fe.if_valid = 1'b1;
    fe.if_inst  = 32'h002081B3;
    fe.if_pc    = 32'h0000_0040;
    rf_rdata1   = 32'd3;
    rf_rdata2   = 32'd4;
    wb_valid    = 1'b0;
    wb_rd       = 5'd0;
    wb_data     = 32'd0;
    stall_in    = 1'b1;
    flush       = 1'b1;
    #1;
    tick();
    tick();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_inst", alu_inst, 32'h0000_0013);

    rst_n       = 1'b1;
    stall_in    = 1'b0;
    flush       = 1'b0;
    fe.if_valid = 1'b0;
    tick();
    chk("bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("bub_inst", alu_inst, 32'h0000_0013);
    chk("bub_a", alu_data_a, 32'd0);
    chk("bub_b", alu_data_b, 32'd0);
    chk("bub_s2", ex_rs2_data, 32'd0);
    chk("bub_pc", ex_pc, 32'd0);
    chk("bub_sel", {28'd0, alu_sel}, 32'd0);

    // add x3,x1,x2
    fe.if_valid = 1'b1;
    fe.if_inst  = 32'h002081B3;
    fe.if_pc    = 32'h0000_0010;
    rf_rdata1   = 32'd5;
    rf_rdata2   = 32'd7;
    #1;
    chk("rs1_addr", {27'd0, rs1_addr}, 32'd1);
    chk("rs2_addr", {27'd0, rs2_addr}, 32'd2);
    chk("rdy_hi", {31'd0, fe.if_ready}, 32'd1);
    tick();
    chk("add_valid", {31'd0, ex_valid}, 32'd1);
    chk("add_a", alu_data_a, 32'd5);
    chk("add_b", alu_data_b, 32'd7);
    chk("add_sel", {28'd0, alu_sel}, 32'h0);
    chk("add_pc", ex_pc, 32'h10);
    chk("add_inst", alu_inst, 32'h002081B3);

    // srai x5,x6,3
    fe.if_inst = 32'h40335293;
    rf_rdata1  = 32'h8000_0000;
    tick();
    chk("srai_sel", {28'd0, alu_sel}, 32'hD);
    chk("srai_a", alu_data_a, 32'h8000_0000);
    chk("srai_sh", {27'd0, alu_data_b[4:0]}, 32'd3);

    // andi x1,x2,-1: inst[30]=1 must not leak into sel
    fe.if_inst = 32'hFFF17093;
    tick();
    chk("andi_sel", {28'd0, alu_sel}, 32'h7);
    chk("andi_b", alu_data_b, 32'hFFFF_FFFF);

    // add x4,x3,x3 with forwarding from x3
    fe.if_inst = 32'h00318233;
    rf_rdata1  = 32'd1;
    rf_rdata2  = 32'd1;
    wb_valid   = 1'b1;
    wb_rd      = 5'd3;
    wb_data    = 32'd9;
    tick();
    chk("fwd_a", alu_data_a, 32'd9);
    chk("fwd_b", alu_data_b, 32'd9);
    wb_rd = 5'd0;
    tick();
    chk("fwd0_a", alu_data_a, 32'd1);
    chk("fwd0_b", alu_data_b, 32'd1);
    wb_valid = 1'b0;

    // beq x1,x2,-4 at pc 0x100
    fe.if_inst = 32'hFE208EE3;
    fe.if_pc   = 32'h0000_0100;
    rf_rdata1  = 32'd11;
    rf_rdata2  = 32'd22;
    tick();
    chk("br_a", alu_data_a, 32'h100);
    chk("br_b", alu_data_b, 32'hFFFF_FFFC);
    chk("br_s2", ex_rs2_data, 32'd22);
    chk("br_sel", {28'd0, alu_sel}, 32'h0);

    // sw x2,8(x1)
    fe.if_inst = 32'h0020A423;
    tick();
    chk("sw_a", alu_data_a, 32'd11);
    chk("sw_b", alu_data_b, 32'd8);
    chk("sw_s2", ex_rs2_data, 32'd22);

    // auipc x5,0xFFFFF at pc 0x200
    fe.if_inst = 32'hFFFFF297;
    fe.if_pc   = 32'h0000_0200;
    tick();
    chk("auipc_a", alu_data_a, 32'h200);
    chk("auipc_b", alu_data_b, 32'hFFFF_F000);

    // sub x7,x1,x2, then stall 3 cycles with a wb to x2 in cycle 2
    fe.if_inst = 32'h402083B3;
    rf_rdata1  = 32'd10;
    rf_rdata2  = 32'd20;
    tick();
    chk("sub_sel", {28'd0, alu_sel}, 32'h8);
    chk("sub_a", alu_data_a, 32'd10);
    chk("sub_b", alu_data_b, 32'd20);
    stall_in   = 1'b1;
    fe.if_inst = 32'hFFF17093;
    rf_rdata1  = 32'd55;
    #1;
    chk("stl_rdy1", {31'd0, fe.if_ready}, 32'd0);
    tick();
    chk("stl1_a", alu_data_a, 32'd10);
    chk("stl1_b", alu_data_b, 32'd20);
    wb_valid = 1'b1;
    wb_rd    = 5'd2;
    wb_data  = 32'd100;
    #1;
    chk("stl_rdy2", {31'd0, fe.if_ready}, 32'd0);
    tick();
    chk("stl2_a", alu_data_a, 32'd10);
    chk("stl2_b", alu_data_b, 32'd100);
    chk("stl2_s2", ex_rs2_data, 32'd100);
    wb_valid = 1'b0;
    #1;
    chk("stl_rdy3", {31'd0, fe.if_ready}, 32'd0);
    tick();
    chk("stl3_b", alu_data_b, 32'd100);
    chk("stl3_inst", alu_inst, 32'h402083B3);
    chk("stl3_valid", {31'd0, ex_valid}, 32'd1);

    // flush while stalled
    flush = 1'b1;
    tick();
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_inst", alu_inst, 32'h0000_0013);

    // lui x1,0x12345 offered during flush: not captured
    stall_in   = 1'b0;
    fe.if_inst = 32'h123450B7;
    fe.if_pc   = 32'h0000_0300;
    tick();
    chk("fl2_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl2_inst", alu_inst, 32'h0000_0013);
    flush = 1'b0;
    tick();
    chk("lui_valid", {31'd0, ex_valid}, 32'd1);
    chk("lui_a", alu_data_a, 32'd0);
    chk("lui_b", alu_data_b, 32'h1234_5000);
    chk("lui_inst", alu_inst, 32'h123450B7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
